// File: rtl/apb_interconnect_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_ic_pkg : FSM state encodings, fabric error codes and clog2 helper
// Revision   : 1.0
// ---------------------------------------------------------------------------
package apb_ic_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACC_SLV = 2'd1;
  localparam logic [1:0] ST_ACC_DEF = 2'd2;

  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_PROTOCOL = 2'b11;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_interconnect_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_interconnect_if : master-side APB, slave-side select/response and error capture bundle
// Revision            : 1.0
// ---------------------------------------------------------------------------
interface apb_interconnect_if #(
  parameter int NSLV = 4,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic                 PSEL;
  logic                 PENABLE;
  logic [AW-1:0]        PADDR;
  logic                 PREADY;
  logic                 PSLVERR;
  logic [DW-1:0]        PRDATA;
  logic [NSLV-1:0]      S_PSEL;
  logic                 S_PENABLE;
  logic [NSLV-1:0]      S_PREADY;
  logic [NSLV-1:0]      S_PSLVERR;
  logic [NSLV*DW-1:0]   S_PRDATA;
  logic                 ERR_VALID;
  logic [1:0]           ERR_CODE;
  logic [AW-1:0]        ERR_ADDR;

  modport slave (
    input  PSEL, PENABLE, PADDR, S_PREADY, S_PSLVERR, S_PRDATA,
    output PREADY, PSLVERR, PRDATA, S_PSEL, S_PENABLE, ERR_VALID, ERR_CODE, ERR_ADDR
  );

  modport master (
    output PSEL, PENABLE, PADDR, S_PREADY, S_PSLVERR, S_PRDATA,
    input  PREADY, PSLVERR, PRDATA, S_PSEL, S_PENABLE, ERR_VALID, ERR_CODE, ERR_ADDR
  );
endinterface
`default_nettype wire

// File: rtl/apb_interconnect_addr_match.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_addr_match : combinational base/mask decode, lowest matching index wins
// Revision       : 1.0
// ---------------------------------------------------------------------------
module apb_addr_match
  import apb_ic_pkg::*;
#(
  parameter int              NSLV       = 4,
  parameter int              AW         = 32,
  parameter int              IW         = (NSLV > 1) ? clog2(NSLV) : 1,
  parameter logic [NSLV*AW-1:0] BASE_ADDRS = '0,
  parameter logic [NSLV*AW-1:0] ADDR_MASKS = '0
) (
  input  wire logic [AW-1:0] i_addr,
  output logic      [IW-1:0] o_idx,
  output logic               o_hit
);

  // Scan from the top down so the lowest matching slave overwrites last.
  always_comb begin
    o_idx = '0;
    o_hit = 1'b0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((i_addr & ADDR_MASKS[i*AW +: AW]) == BASE_ADDRS[i*AW +: AW]) begin
        o_hit = 1'b1;
        o_idx = IW'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_interconnect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// apb_interconnect : 1-to-NSLV APB fabric with default error slave, watchdog and error capture
// Revision         : 1.0
// ---------------------------------------------------------------------------
module apb_interconnect
  import apb_ic_pkg::*;
#(
  parameter int                 NSLV       = 4,
  parameter int                 AW         = 32,
  parameter int                 DW         = 32,
  parameter logic [NSLV*AW-1:0] BASE_ADDRS = {32'h4000_3000, 32'h4000_2000, 32'h4000_1000, 32'h4000_0000},
  parameter logic [NSLV*AW-1:0] ADDR_MASKS = {4{32'hFFFF_F000}},
  parameter int                 TIMEOUT    = 16
) (
  input wire logic          PCLK,
  input wire logic          PRESETn,
  apb_interconnect_if.slave bus
);

  localparam int c_iw = (NSLV > 1) ? clog2(NSLV) : 1;
  localparam int c_cw = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cw-1:0] c_cnt_max = '1;
  localparam logic [c_cw-1:0] c_timeout = c_cw'(TIMEOUT);

  logic [1:0]      r_state, w_state_nxt;
  logic [c_iw-1:0] r_idx, w_win;
  logic            w_hit;
  logic [c_cw-1:0] r_cnt, w_cnt_nxt;
  logic [AW-1:0]   r_addr;
  logic            r_err_valid;
  logic [1:0]      r_err_code;
  logic [AW-1:0]   r_err_addr;
  logic            w_err_set;
  logic [1:0]      w_err_code;
  logic [AW-1:0]   w_err_addr;
  logic            w_slv_ready, w_slv_err, w_timeout;
  logic [DW-1:0]   w_slv_data;

  apb_addr_match #(
    .NSLV      (NSLV),
    .AW        (AW),
    .IW        (c_iw),
    .BASE_ADDRS(BASE_ADDRS),
    .ADDR_MASKS(ADDR_MASKS)
  ) u_match (
    .i_addr(bus.PADDR),
    .o_idx (w_win),
    .o_hit (w_hit)
  );

  assign w_slv_ready = bus.S_PREADY[r_idx];
  assign w_slv_err   = bus.S_PSLVERR[r_idx];
  assign w_slv_data  = bus.S_PRDATA[r_idx*DW +: DW];
  // A slave that becomes ready on the expiry cycle still completes normally.
  assign w_timeout   = (TIMEOUT != 0) && (r_cnt == c_timeout) && !w_slv_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_err_set     = 1'b0;
    w_err_code    = '0;
    w_err_addr    = r_addr;
    bus.S_PSEL    = '0;
    bus.S_PENABLE = 1'b0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    bus.PRDATA    = '0;
    if (PRESETn) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            if (w_hit) begin
              bus.S_PSEL[w_win] = 1'b1;
              w_state_nxt       = ST_ACC_SLV;
            end else begin
              w_state_nxt       = ST_ACC_DEF;
            end
          end else if (bus.PSEL) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = 1'b1;
            w_err_set   = 1'b1;
            w_err_code  = ERR_PROTOCOL;
            w_err_addr  = bus.PADDR;
          end
        end
        ST_ACC_SLV: begin
          if (!bus.PSEL) begin
            w_state_nxt = ST_IDLE;
          end else begin
            bus.S_PSEL[r_idx] = 1'b1;
            bus.S_PENABLE     = bus.PENABLE;
            if (w_timeout) begin
              bus.PREADY  = 1'b1;
              bus.PSLVERR = 1'b1;
              w_err_set   = 1'b1;
              w_err_code  = ERR_TIMEOUT;
              w_state_nxt = ST_IDLE;
            end else begin
              bus.PREADY  = w_slv_ready;
              bus.PSLVERR = w_slv_err & w_slv_ready;
              bus.PRDATA  = w_slv_ready ? w_slv_data : '0;
              if (w_slv_ready) w_state_nxt = ST_IDLE;
            end
            if (!bus.PREADY) w_cnt_nxt = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + 1'b1;
          end
        end
        ST_ACC_DEF: begin
          w_state_nxt = ST_IDLE;
          if (bus.PSEL) begin
            bus.PREADY  = 1'b1;
            bus.PSLVERR = 1'b1;
            w_err_set   = 1'b1;
            w_err_code  = ERR_UNMAPPED;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= '0;
      r_err_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err_valid <= w_err_set;
      if (r_state == ST_IDLE && bus.PSEL && !bus.PENABLE) begin
        r_idx  <= w_win;
        r_addr <= bus.PADDR;
      end
      if (w_err_set) begin
        r_err_code <= w_err_code;
        r_err_addr <= w_err_addr;
      end
    end
  end

  assign bus.ERR_VALID = r_err_valid;
  assign bus.ERR_CODE  = r_err_code;
  assign bus.ERR_ADDR  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_apb_interconnect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_apb_interconnect : randomized scoreboard bench for apb_interconnect
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_apb_interconnect;

  localparam int NSLV    = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [NSLV-1:0] sel;
    int              waits;
    logic            slverr;
    logic [DW-1:0]   rdata;
    logic [1:0]      ecode;
    logic [AW-1:0]   eaddr;
  } exp_t;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_interconnect_if #(.NSLV(NSLV), .AW(AW), .DW(DW)) bus ();

  apb_interconnect #(.NSLV(NSLV), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference map: four 4 KiB pages starting at 0x4000_0000, one per slave.
  function automatic int model_decode(input logic [AW-1:0] a);
    logic [19:0] page;
    page = a[31:12];
    if (page >= 20'h40000 && page <= 20'h40003) return int'(page - 20'h40000);
    return -1;
  endfunction

  // Slave-side stimulus: the target slave follows its script, all others are noise.
  int            tgt = -1;
  int            tgt_waits;
  logic          tgt_err;
  logic [DW-1:0] tgt_data;

  task automatic drive_slaves(input int k);
    logic [NSLV-1:0]    rdy, er;
    logic [NSLV*DW-1:0] dat;
    for (int j = 0; j < NSLV; j++) begin
      rdy[j]          = 1'($urandom_range(0, 1));
      er[j]           = 1'($urandom_range(0, 1));
      dat[j*DW +: DW] = $urandom;
    end
    if (tgt >= 0) begin
      rdy[tgt]          = (k > 0) && (k == tgt_waits + 1);
      er[tgt]           = tgt_err;
      dat[tgt*DW +: DW] = tgt_data;
    end
    bus.S_PREADY  = rdy;
    bus.S_PSLVERR = er;
    bus.S_PRDATA  = dat;
  endtask

  function automatic exp_t model_xfer(input logic [AW-1:0] addr, input int waits,
                                      input logic serr, input logic [DW-1:0] data);
    exp_t e;
    int   s;
    s = model_decode(addr);
    e.sel = '0; e.waits = 0; e.slverr = 1'b1; e.rdata = '0; e.ecode = 2'b00; e.eaddr = addr;
    if (s < 0) begin
      e.ecode = 2'b01;
    end else begin
      e.sel[s] = 1'b1;
      if (TIMEOUT != 0 && waits > TIMEOUT) begin
        e.waits = TIMEOUT;
        e.ecode = 2'b10;
      end else begin
        e.waits  = waits;
        e.slverr = serr;
        e.rdata  = data;
      end
    end
    return e;
  endfunction

  task automatic xfer(input logic [AW-1:0] addr, input int waits,
                      input logic serr, input logic [DW-1:0] data);
    exp_t e;
    e = model_xfer(addr, waits, serr, data);
    @(posedge PCLK); #1;
    q.push_back(e);
    tgt = model_decode(addr); tgt_waits = waits; tgt_err = serr; tgt_data = data;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = addr;
    drive_slaves(0);
    for (int k = 1; k <= e.waits + 1; k++) begin
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      drive_slaves(k);
    end
  endtask

  task automatic protocol_err(input logic [AW-1:0] addr);
    exp_t e;
    e.sel = '0; e.waits = 0; e.slverr = 1'b1; e.rdata = '0; e.ecode = 2'b11; e.eaddr = addr;
    @(posedge PCLK); #1;
    q.push_back(e);
    tgt = -1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PADDR = addr;
    drive_slaves(0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge PCLK); #1;
      tgt = -1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      drive_slaves(0);
    end
  endtask

  task automatic reset_mid_access();
    exp_t e;
    e = model_xfer(32'h4000_2010, 5, 1'b0, 32'h0);
    @(posedge PCLK); #1;
    q.push_back(e);
    tgt = 2; tgt_waits = 5; tgt_err = 1'b0; tgt_data = 32'h0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PADDR = 32'h4000_2010;
    drive_slaves(0);
    repeat (2) begin
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      drive_slaves(1);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  // Monitor: compares every DUT response against the head of the scoreboard queue.
  exp_t          m_e;
  int            acc_cnt = 0;
  logic          pend_v = 1'b0;
  logic [1:0]    pend_c, hold_c = 2'b00;
  logic [AW-1:0] pend_a, hold_a = '0;

  always @(negedge PCLK) begin
    if (!PRESETn) begin
      chk("rst_ctrl", {bus.PREADY, bus.PSLVERR, bus.S_PENABLE, bus.ERR_VALID, bus.ERR_CODE, bus.S_PSEL}, 64'h0);
      chk("rst_prdata", bus.PRDATA, 64'h0);
      chk("rst_err_addr", bus.ERR_ADDR, 64'h0);
      q.delete();
      acc_cnt = 0; pend_v = 1'b0; hold_c = 2'b00; hold_a = '0;
    end else begin
      chk("err_valid", bus.ERR_VALID, pend_v);
      if (pend_v) begin hold_c = pend_c; hold_a = pend_a; end
      chk("err_code", bus.ERR_CODE, hold_c);
      chk("err_addr", bus.ERR_ADDR, hold_a);
      pend_v = 1'b0;
      if (!bus.PSEL) begin
        chk("idle_out", {bus.PREADY, bus.S_PSEL}, 64'h0);
      end else if (q.size() == 0) begin
        chk("no_expectation", 64'h1, 64'h0);
      end else begin
        m_e = q[0];
        chk("s_psel", bus.S_PSEL, m_e.sel);
        chk("s_penable", bus.S_PENABLE, bus.PENABLE && (m_e.sel != '0));
        if (!bus.PENABLE) begin
          chk("setup_pready", bus.PREADY, 64'h0);
          chk("prev_complete", acc_cnt, 64'h0);
          acc_cnt = 0;
        end else begin
          acc_cnt++;
          if (bus.PREADY) begin
            void'(q.pop_front());
            chk("waits", acc_cnt - 1, m_e.waits);
            chk("pslverr", bus.PSLVERR, m_e.slverr);
            chk("prdata", bus.PRDATA, m_e.rdata);
            acc_cnt = 0;
            if (m_e.ecode != 2'b00) begin
              pend_v = 1'b1; pend_c = m_e.ecode; pend_a = m_e.eaddr;
            end
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            kind, slv, waits;
    logic [AW-1:0] a;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = '0;
    bus.S_PREADY = '0; bus.S_PSLVERR = '0; bus.S_PRDATA = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    xfer(32'h4000_1004, 2, 1'b0, 32'h1111_2222);
    xfer(32'h4000_2000, 0, 1'b0, 32'hDEAD_BEEF);
    xfer(32'h5000_0000, 0, 1'b0, 32'h0);
    idle(1);
    xfer(32'h4000_0010, 100, 1'b0, 32'h0);
    xfer(32'h4000_0010, TIMEOUT, 1'b0, 32'h1234_5678);
    xfer(32'h4000_3008, 1, 1'b1, 32'hCAFE_F00D);
    xfer(32'h4000_000C, 0, 1'b0, 32'hA5A5_5A5A);
    reset_mid_access();
    idle(1);
    protocol_err(32'h4000_3008);
    xfer(32'h4000_1000, 0, 1'b0, 32'h0BAD_F00D);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      slv  = $urandom_range(0, NSLV - 1);
      a    = 32'h4000_0000 | (32'(slv) << 12) | ($urandom & 32'hFFF);
      if (kind == 0) begin
        protocol_err(a);
      end else if (kind == 1) begin
        xfer(32'h8000_0000 | $urandom, 0, 1'b0, 32'h0);
      end else begin
        waits = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
        xfer(a, waits, 1'($urandom_range(0, 1)), $urandom);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    idle(3);
    chk("queue_drained", q.size(), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
